// File: rtl/dma_write.sv
// dma_write: stream-to-memory DMA write engine.
// Packs PW-bit primitives into DW-bit words and bursts them onto the bus.
module dma_write #(
    parameter int          PW     = 32,
    parameter int          AW     = 32,
    parameter int          DW     = 64,
    parameter int          DMA_BL = 3,
    parameter int          BL     = 4,
    parameter int          APB_AW = 5,
    parameter logic [31:0] ID     = 32'hCE6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpb_r,
    input  logic              cpb_w,
    input  logic [APB_AW-1:0] cpb_a,
    input  logic [31:0]       cpb_d,
    output logic [31:0]       cpb_q,
    output logic              irq,
    output logic              src_str_rdy,
    input  logic              src_str_val,
    input  logic [PW-1:0]     src_str_d,
    input  logic              dst_bus_wrdy,
    output logic              dst_bus_wval,
    output logic [BL-1:0]     dst_bus_wlen,
    output logic [AW-1:0]     dst_bus_waddr,
    output logic [DW-1:0]     dst_bus_wdata
);
    localparam int R     = DW / PW;
    localparam int SW    = (R > 1) ? $clog2(R) : 1;
    localparam int MAXB  = 2 ** DMA_BL;
    localparam int DEPTH = 2 ** (DMA_BL + 1);
    localparam int PTRW  = DMA_BL + 1;
    localparam int LVLW  = DMA_BL + 2;
    localparam logic [SW-1:0] SUB_LAST = SW'(R - 1);

    typedef enum logic [1:0] {IDLE, WAIT, BURST, DONE} state_t;

    state_t state_q, state_d;

    logic            en_q;
    logic            irq_q;
    logic [AW-1:0]   da_q;
    logic [31:0]     lr_q;
    logic [AW-1:0]   addr_q;
    logic [31:0]     rem_q;
    logic [31:0]     plen_q;
    logic [31:0]     packed_q;
    logic [AW-1:0]   waddr_q;
    logic [BL-1:0]   wlen_q;
    logic [BL-1:0]   beat_q;

    logic [DW-1:0]   mem_q [DEPTH];
    logic [PTRW-1:0] wp_q;
    logic [PTRW-1:0] rp_q;
    logic [LVLW-1:0] lvl_q;
    logic [DW-1:0]   pack_q;
    logic [DW-1:0]   pack_d;
    logic [SW-1:0]   sub_q;

    logic        wr_cr, wr_sr, wr_da, wr_lr;
    logic        start, busy, flush;
    logic        fifo_full, acc, push, pop, last_beat;
    logic [31:0] n_d;
    logic        unused_ok;

    assign unused_ok = cpb_r;

    assign wr_cr = cpb_w && (cpb_a == APB_AW'(1));
    assign wr_sr = cpb_w && (cpb_a == APB_AW'(2));
    assign wr_da = cpb_w && (cpb_a == APB_AW'(3));
    assign wr_lr = cpb_w && (cpb_a == APB_AW'(4));

    assign busy  = state_q != IDLE;
    assign flush = state_q == IDLE;
    assign start = wr_cr && cpb_d[0] && !en_q && !busy;

    assign n_d = (rem_q > 32'(MAXB)) ? 32'(MAXB) : rem_q;

    assign fifo_full   = lvl_q == LVLW'(DEPTH);
    assign src_str_rdy = en_q && busy && !fifo_full
                         && (packed_q < plen_q);
    assign acc         = src_str_val && src_str_rdy;
    assign push        = acc && (sub_q == SUB_LAST);
    assign pop         = dst_bus_wval && dst_bus_wrdy;
    assign last_beat   = pop && (beat_q == wlen_q - BL'(1));

    assign irq           = irq_q;
    assign dst_bus_wlen  = wlen_q;
    assign dst_bus_waddr = waddr_q;
    assign dst_bus_wdata = dst_bus_wval ? mem_q[rp_q] : '0;

    // Register file: control, status and transfer setup.
    always_ff @(posedge clk) begin
        if (rst) begin
            en_q  <= 1'b0;
            irq_q <= 1'b0;
            da_q  <= '0;
            lr_q  <= '0;
        end else begin
            if (wr_cr) en_q <= cpb_d[0];
            if (wr_da) da_q <= AW'(cpb_d);
            if (wr_lr) lr_q <= cpb_d;
            if (state_q == DONE) irq_q <= 1'b1;
            else if (wr_sr && cpb_d[0]) irq_q <= 1'b0;
        end
    end

    // Combinational register readback.
    always_comb begin
        cpb_q = ID;
        case (cpb_a)
            APB_AW'(1): cpb_q = {31'd0, en_q};
            APB_AW'(2): cpb_q = {30'd0, busy, irq_q};
            APB_AW'(3): cpb_q = 32'(da_q);
            APB_AW'(4): cpb_q = lr_q;
            default:    cpb_q = ID;
        endcase
    end

    // Next-state and bus valid; an aborted burst still finishes.
    always_comb begin
        state_d      = state_q;
        dst_bus_wval = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) state_d = WAIT;
            end
            WAIT: begin
                if (!en_q) state_d = IDLE;
                else if (rem_q == 32'd0) state_d = DONE;
                else if (32'(lvl_q) >= n_d) state_d = BURST;
            end
            BURST: begin
                dst_bus_wval = 1'b1;
                if (last_beat) begin
                    if (!en_q) state_d = IDLE;
                    else if (rem_q == 32'(wlen_q)) state_d = DONE;
                    else state_d = WAIT;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State register plus working address, count and burst header.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            rem_q   <= '0;
            plen_q  <= '0;
            waddr_q <= '0;
            wlen_q  <= '0;
            beat_q  <= '0;
        end else begin
            state_q <= state_d;
            if (start) begin
                addr_q <= da_q;
                rem_q  <= lr_q;
                plen_q <= lr_q;
            end
            if (state_q == WAIT && state_d == BURST) begin
                waddr_q <= addr_q;
                wlen_q  <= BL'(n_d);
                beat_q  <= '0;
            end else if (pop) begin
                beat_q <= beat_q + BL'(1);
            end
            if (last_beat) begin
                addr_q <= addr_q + AW'(32'(wlen_q) * (DW / 8));
                rem_q  <= rem_q - 32'(wlen_q);
            end
        end
    end

    // Little-endian slot insert of the incoming primitive.
    always_comb begin
        pack_d = pack_q;
        pack_d[int'(sub_q) * PW +: PW] = src_str_d;
    end

    // Packer: slot index and count of words handed to the FIFO.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            pack_q   <= '0;
            sub_q    <= '0;
            packed_q <= '0;
        end else if (acc) begin
            pack_q <= pack_d;
            sub_q  <= push ? '0 : sub_q + SW'(1);
            if (push) packed_q <= packed_q + 32'd1;
        end
    end

    // FIFO pointers and level; emptied whenever the engine is idle.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wp_q  <= '0;
            rp_q  <= '0;
            lvl_q <= '0;
        end else begin
            if (push) wp_q <= wp_q + PTRW'(1);
            if (pop) rp_q <= rp_q + PTRW'(1);
            lvl_q <= lvl_q + LVLW'(push) - LVLW'(pop);
        end
    end

    // FIFO storage.
    always_ff @(posedge clk) begin
        if (push) mem_q[wp_q] <= pack_d;
    end
endmodule

// File: tb/tb_dma_write.sv
// tb_dma_write: directed and randomized bench for dma_write.
// Bursts and beat data are compared against a queue-based transfer model.
module tb_dma_write;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cpb_r = 1'b0;
    logic        cpb_w = 1'b0;
    logic [4:0]  cpb_a = '0;
    logic [31:0] cpb_d = '0;
    logic [31:0] cpb_q;
    logic        irq;
    logic        src_str_rdy;
    logic        src_str_val;
    logic [31:0] src_str_d;
    logic        dst_bus_wrdy;
    logic        dst_bus_wval;
    logic [3:0]  dst_bus_wlen;
    logic [31:0] dst_bus_waddr;
    logic [63:0] dst_bus_wdata;

    always #5 clk = ~clk;

    dma_write dut (
        .clk          (clk),
        .rst          (rst),
        .cpb_r        (cpb_r),
        .cpb_w        (cpb_w),
        .cpb_a        (cpb_a),
        .cpb_d        (cpb_d),
        .cpb_q        (cpb_q),
        .irq          (irq),
        .src_str_rdy  (src_str_rdy),
        .src_str_val  (src_str_val),
        .src_str_d    (src_str_d),
        .dst_bus_wrdy (dst_bus_wrdy),
        .dst_bus_wval (dst_bus_wval),
        .dst_bus_wlen (dst_bus_wlen),
        .dst_bus_waddr(dst_bus_waddr),
        .dst_bus_wdata(dst_bus_wdata)
    );

    int n_assert = 0;
    int n_fail   = 0;

    logic [31:0] prims[$];
    int          sidx = 0;
    int          snum = 0;
    bit          str_rand = 1'b0;
    bit          bus_rand = 1'b0;

    logic [31:0] obs_addr[$];
    int          obs_len[$];
    logic [63:0] obs_data[$];
    bit          in_burst = 1'b0;
    logic [31:0] cur_addr;
    logic [3:0]  cur_len;
    int          beats = 0;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Stream source: walks the prims queue, optionally with random valid.
    initial begin : stream
        bit fire;
        src_str_val = 1'b0;
        src_str_d   = '0;
        forever begin
            @(negedge clk);
            fire = src_str_val && src_str_rdy;
            @(posedge clk);
            #1;
            if (fire) sidx++;
            if (sidx < snum) begin
                src_str_val = str_rand ? 1'($urandom_range(0, 1)) : 1'b1;
                src_str_d   = prims[sidx];
            end else begin
                src_str_val = 1'b0;
            end
        end
    end

    // Bus sink: ready always or randomly.
    initial begin : bus
        dst_bus_wrdy = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            dst_bus_wrdy = bus_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Bus monitor: records bursts and beats, checks burst integrity.
    initial begin : mon
        forever begin
            @(negedge clk);
            if (rst) begin
                in_burst = 1'b0;
            end else if (dst_bus_wval) begin
                if (!in_burst) begin
                    in_burst = 1'b1;
                    beats    = 0;
                    cur_addr = dst_bus_waddr;
                    cur_len  = dst_bus_wlen;
                    obs_addr.push_back(dst_bus_waddr);
                    obs_len.push_back(int'(dst_bus_wlen));
                end else begin
                    chk("waddr_stable", dst_bus_waddr, cur_addr);
                    chk("wlen_stable", dst_bus_wlen, cur_len);
                end
                if (dst_bus_wrdy) begin
                    obs_data.push_back(dst_bus_wdata);
                    beats++;
                    if (beats == int'(cur_len)) in_burst = 1'b0;
                end
            end else if (in_burst) begin
                chk("wval_gap", dst_bus_wval, 1);
                in_burst = 1'b0;
            end
        end
    end

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        cpb_w = 1'b1;
        cpb_a = a;
        cpb_d = d;
        @(posedge clk);
        #1;
        cpb_w = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [4:0] a,
                      input logic [31:0] exp);
        cpb_a = a;
        #1;
        chk(tag, cpb_q, exp);
    endtask

    task automatic load(input int count);
        prims.delete();
        obs_addr.delete();
        obs_len.delete();
        obs_data.delete();
        for (int i = 0; i < count; i++) prims.push_back($urandom);
        sidx = 0;
        snum = count;
    endtask

    task automatic wait_irq(input string tag, input int limit);
        int c = 0;
        while (!irq && c < limit) begin
            @(posedge clk);
            #1;
            c++;
        end
        chk(tag, irq, 1);
    endtask

    // Model: lr words split into bursts of at most 8, addresses
    // advancing 8 bytes per word, word i = {prim 2i+1, prim 2i}.
    task automatic check_xfer(input string tag, input logic [31:0] da,
                              input int lr);
        int          rem = lr;
        int          k = 0;
        int          n;
        logic [31:0] a = da;
        chk($sformatf("%s_nburst", tag), obs_addr.size(), (lr + 7) / 8);
        while (rem > 0) begin
            n = (rem > 8) ? 8 : rem;
            if (k < obs_addr.size()) begin
                chk($sformatf("%s_addr%0d", tag, k), obs_addr[k], a);
                chk($sformatf("%s_len%0d", tag, k), obs_len[k], n);
            end
            a = a + 32'(n * 8);
            rem = rem - n;
            k++;
        end
        chk($sformatf("%s_nwords", tag), obs_data.size(), lr);
        for (int i = 0; i < lr && i < obs_data.size(); i++)
            chk($sformatf("%s_data%0d", tag, i), obs_data[i],
                {prims[2 * i + 1], prims[2 * i]});
    endtask

    initial begin : main
        int          c;
        int          lr;
        logic [31:0] da;

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        chk("rst_wval", dst_bus_wval, 0);
        chk("rst_waddr", dst_bus_waddr, 0);
        chk("rst_wlen", dst_bus_wlen, 0);
        chk("rst_wdata", dst_bus_wdata, 0);
        chk("rst_irq", irq, 0);
        chk("rst_rdy", src_str_rdy, 0);
        rd("rst_cr", 1, 0);
        rd("rst_sr", 2, 0);
        rd("rst_da", 3, 0);
        rd("rst_lr", 4, 0);

        rd("idr", 0, 32'hCE6);
        wr(3, 32'h1000);
        wr(4, 16);
        rd("da_rb", 3, 32'h1000);
        rd("lr_rb", 4, 16);
        rd("addr7", 7, 32'hCE6);

        load(32);
        wr(1, 1);
        rd("t2_busy", 2, 2);
        wait_irq("t2_irq", 2000);
        check_xfer("t2", 32'h1000, 16);
        rd("t2_sr", 2, 1);
        wr(2, 1);
        chk("t2_irq_clr", irq, 0);
        wr(1, 0);

        wr(3, 32'h2000);
        wr(4, 11);
        load(23);
        wr(1, 1);
        wait_irq("t3_irq", 2000);
        check_xfer("t3", 32'h2000, 11);
        chk("t3_held_idx", sidx, 22);
        chk("t3_held_val", src_str_val, 1);
        chk("t3_held_rdy", src_str_rdy, 0);
        snum = 0;
        wr(2, 1);
        wr(1, 0);

        bus_rand = 1'b1;
        str_rand = 1'b1;
        wr(3, 32'hFFFF_FFC0);
        wr(4, 20);
        load(40);
        wr(1, 1);
        wait_irq("t4a_irq", 5000);
        check_xfer("t4a", 32'hFFFF_FFC0, 20);
        wr(2, 1);
        wr(1, 0);

        lr = $urandom_range(1, 30);
        da = $urandom & 32'hFFFF_FFF8;
        wr(3, da);
        wr(4, lr);
        load(2 * lr);
        wr(1, 1);
        wait_irq("t4b_irq", 8000);
        check_xfer("t4b", da, lr);
        wr(2, 1);
        wr(1, 0);
        bus_rand = 1'b0;
        str_rand = 1'b0;

        wr(3, 32'h6000);
        wr(4, 0);
        load(0);
        wr(1, 1);
        chk("t5_irq_c1", irq, 0);
        @(posedge clk);
        #1;
        chk("t5_irq_c2", irq, 0);
        wr(2, 1);
        chk("t5_set_wins", irq, 1);
        chk("t5_nburst", obs_addr.size(), 0);
        rd("t5_sr", 2, 1);
        wr(2, 1);
        chk("t5_irq_clr", irq, 0);
        wr(1, 0);

        wr(3, 32'h3000);
        wr(4, 16);
        load(32);
        wr(1, 1);
        c = 0;
        while (!dst_bus_wval && c < 200) begin
            @(posedge clk);
            #1;
            c++;
        end
        chk("t6_burst_start", dst_bus_wval, 1);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        wr(1, 0);
        cpb_a = 2;
        #1;
        c = 0;
        while (cpb_q[1] && c < 200) begin
            @(posedge clk);
            #1;
            c++;
        end
        chk("t6_busy", cpb_q[1], 0);
        chk("t6_irq", irq, 0);
        chk("t6_nburst", obs_addr.size(), 1);
        chk("t6_nbeats", obs_data.size(), 8);
        for (int i = 0; i < 8 && i < obs_data.size(); i++)
            chk($sformatf("t6_data%0d", i), obs_data[i],
                {prims[2 * i + 1], prims[2 * i]});
        @(posedge clk);
        #1;
        chk("t6_no_more", obs_data.size(), 8);

        wr(3, 32'h4000);
        wr(4, 4);
        load(8);
        wr(1, 1);
        wait_irq("t6_fresh_irq", 2000);
        check_xfer("t6_fresh", 32'h4000, 4);
        wr(2, 1);
        wr(1, 0);

        wr(3, 32'h5000);
        wr(4, 8);
        load(16);
        wr(1, 1);
        c = 0;
        while (!dst_bus_wval && c < 200) begin
            @(posedge clk);
            #1;
            c++;
        end
        chk("t6r_burst_start", dst_bus_wval, 1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("t6r_wval", dst_bus_wval, 0);
        chk("t6r_waddr", dst_bus_waddr, 0);
        chk("t6r_wlen", dst_bus_wlen, 0);
        chk("t6r_wdata", dst_bus_wdata, 0);
        chk("t6r_irq", irq, 0);
        chk("t6r_rdy", src_str_rdy, 0);
        rst = 1'b0;
        snum = 0;
        rd("t6r_cr", 1, 0);
        rd("t6r_sr", 2, 0);
        rd("t6r_da", 3, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end
endmodule
